// File: rtl/spi_pkg.sv
// Shared types for the 3-wire SPI link: receiver FSM state and the default word width.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_rx_state_t;

    localparam int SPI_DATA_W = 12;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with one extra delay flop for rise/fall detection.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic                   dly_reg;

    // Reset to the idle line level so release does not fake an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= {SYNC_STAGES{RST_VAL}};
            dly_reg   <= RST_VAL;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], din};
            dly_reg   <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign sync = stage_reg[SYNC_STAGES-1];
    assign rise = sync & ~dly_reg;
    assign fall = ~sync & dly_reg;

endmodule

// File: rtl/spi_dac_receiver.sv
// DAC-side SPI receiver: oversamples sclk/cs/mosi, shifts one DATA_W-bit word per cs-low
// frame and reports a good word with done or a malformed frame with err.
module spi_dac_receiver
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic s_sclk, sclk_rise, sclk_fall_unused;
    logic s_cs, cs_rise, cs_fall;
    logic s_mosi, mosi_rise_unused, mosi_fall_unused;
    logic s_sclk_unused, s_cs_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .sync(s_sclk), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .sync(s_cs), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .sync(s_mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign s_sclk_unused = s_sclk;
    assign s_cs_unused   = s_cs;

    spi_rx_state_t     state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next, shreg_shifted;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    always_comb begin
        if (LSB_FIRST) shreg_shifted = {s_mosi, shreg_reg[DATA_W-1:1]};
        else           shreg_shifted = {shreg_reg[DATA_W-2:0], s_mosi};
    end

    // cs_rise is judged on the count/ovf after this cycle's sclk_rise, so a final
    // bit arriving together with cs_rise still counts.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        shreg_next = shreg_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    shreg_next = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    if (cnt_reg == CNT_FULL) begin
                        ovf_next = 1'b1;
                    end else begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt_reg + 1'b1;
                    end
                end
                if (cs_rise) begin
                    state_next = IDLE;
                    if (cnt_next == CNT_FULL && !ovf_next) begin
                        dout_next = shreg_next;
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            shreg_reg <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            shreg_reg <= shreg_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign dout = dout_reg;
    assign done = done_reg;
    assign err  = err_reg;
    assign busy = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Scoreboard bench: an LSB-first and an MSB-first receiver see the same frames on shared
// sclk/cs; each frame's expected outcome is queued at cs rise and checked by a monitor.
`timescale 1ns/1ps
module tb_spi_dac_receiver;

    localparam int W = 12;

    logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs = 1'b1, mosi0 = 1'b0, mosi1 = 1'b0;
    logic [W-1:0] dout0, dout1;
    logic done0, err0, busy0, done1, err1, busy1;

    spi_dac_receiver #(.DATA_W(W), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_lsb (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi0),
        .dout(dout0), .done(done0), .err(err0), .busy(busy0)
    );

    spi_dac_receiver #(.DATA_W(W), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_msb (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi1),
        .dout(dout1), .done(done1), .err(err1), .busy(busy1)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
        int           rise_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_good = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic mon(int id, logic d, logic e, logic [W-1:0] dv, logic b);
        exp_t x;
        int   n;
        n = (id == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected_event: done=%0b err=%0b dout=0x%0h, none expected", id, d, e, dv);
        end else begin
            x = (id == 0) ? q0.pop_front() : q1.pop_front();
            $display("dut%0d frame: done=%0b err=%0b dout=0x%03h (expect err=%0b dout=0x%03h)",
                     id, d, e, dv, x.is_err, x.data);
            check($sformatf("dut%0d kind_err", id), 32'(e), 32'(x.is_err));
            check($sformatf("dut%0d done_err_excl", id), 32'(d & e), 32'd0);
            check($sformatf("dut%0d dout", id), 32'(dv), 32'(x.data));
            check($sformatf("dut%0d latency", id), 32'(cyc - x.rise_cyc), 32'd3);
            check($sformatf("dut%0d busy_after", id), 32'(b), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (done0 || err0) mon(0, done0, err0, dout0, busy0);
            if (done1 || err1) mon(1, done1, err1, dout1, busy1);
        end
    end

    task automatic clk_wait(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Bit i of the transmission: word[i] for the LSB-first receiver, word[W-1-i] for MSB-first.
    task automatic send_bits(logic [W-1:0] word, int first, int count);
        for (int i = first; i < first + count; i++) begin
            mosi0 = (i < W) ? word[i]       : 1'($urandom);
            mosi1 = (i < W) ? word[W-1-i]   : 1'($urandom);
            clk_wait(10);
            sclk = 1'b1;
            clk_wait(10);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_high_expect(logic [W-1:0] word, int nbits);
        exp_t x;
        clk_wait(4);
        check("dut0 busy_in_frame", 32'(busy0), 32'd1);
        check("dut1 busy_in_frame", 32'(busy1), 32'd1);
        cs = 1'b1;
        x.rise_cyc = cyc;
        if (nbits == W) begin
            x.is_err  = 1'b0;
            x.data    = word;
            last_good = word;
        end else begin
            x.is_err = 1'b1;
            x.data   = last_good;
        end
        q0.push_back(x);
        q1.push_back(x);
    endtask

    task automatic send_frame(logic [W-1:0] word, int nbits, int gap);
        cs_low();
        send_bits(word, 0, nbits);
        cs_high_expect(word, nbits);
        clk_wait(gap);
    endtask

    task automatic check_reset_outputs();
        check("dut0 rst_dout", 32'(dout0), 32'd0);
        check("dut0 rst_done", 32'(done0), 32'd0);
        check("dut0 rst_err",  32'(err0),  32'd0);
        check("dut0 rst_busy", 32'(busy0), 32'd0);
        check("dut1 rst_dout", 32'(dout1), 32'd0);
        check("dut1 rst_done", 32'(done1), 32'd0);
        check("dut1 rst_err",  32'(err1),  32'd0);
        check("dut1 rst_busy", 32'(busy1), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queues %0d/%0d", q0.size(), q1.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        int           nb, sel;

        clk_wait(3);
        check_reset_outputs();
        rst = 1'b1;
        clk_wait(5);

        // sclk activity with cs high must produce nothing
        repeat (3) begin
            sclk = 1'b1; clk_wait(3);
            sclk = 1'b0; clk_wait(3);
        end

        send_frame(12'hA5C, 12, 8);
        send_frame(12'h123, 12, 8);
        send_frame(W'($urandom), 11, 8);
        send_frame(W'($urandom), 13, 8);
        send_frame(12'h001, 12, 2);
        send_frame(12'hFFF, 12, 8);

        // reset in the middle of a frame, released while cs is still low
        w = 12'h5A3;
        cs_low();
        send_bits(w, 0, 5);
        rst = 1'b0;
        last_good = '0;
        clk_wait(3);
        check_reset_outputs();
        rst = 1'b1;
        clk_wait(4);
        send_bits(w, 5, 7);
        cs_high_expect(w, 7);
        clk_wait(8);
        send_frame(12'h7E1, 12, 8);
        send_frame(12'h800, 12, 8);

        for (int k = 0; k < 25; k++) begin
            w   = W'($urandom);
            sel = $urandom_range(0, 3);
            if (sel <= 1)      nb = W;
            else if (sel == 2) nb = ($urandom_range(0, 1) == 0) ? W - 1 : W + 1;
            else               nb = $urandom_range(0, 15);
            send_frame(w, nb, $urandom_range(2, 6));
        end

        clk_wait(10);
        check("dut0 queue_drained", 32'(q0.size()), 32'd0);
        check("dut1 queue_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
